// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the slice-serial ripple-carry adder.
package rca_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int nslices(input int n, input int slice);
    return n / slice;
  endfunction

  // Index counter needs at least one bit even when a single slice covers the word.
  function automatic int idx_width(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/rca_serial_nb_if.sv
// Request/response bundle for rca_serial_nb; the sub line exists only when SUB_EN is defined.
interface rca_serial_nb_if #(
  parameter int N = 16
);

  // start is taken on a rising clk edge only while busy is low; operands travel with it.
  // busy covers the whole operation, and done pulses for one cycle once sum/co/ovf are valid.
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;

`ifdef SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, co, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, co, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, co, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, co, ovf);
`endif

endinterface

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple-carry adder: {co, sum} = a + b + cin.
module rca_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             co
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[SLICE];

endmodule

// File: rtl/rca_serial_nb.sv
// Multi-cycle N-bit adder processing SLICE bits per clock through one shared rca_slice.
// Optional subtract mode is enabled by defining SUB_EN.
module rca_serial_nb
  import rca_pkg::*;
#(
  parameter int N     = 16,
  parameter int SLICE = 4
) (
  input  logic            clk,
  input  logic            reset,
  rca_serial_nb_if.slave  bus,
  output state_t          fsm_state
);

  localparam int             NSL      = nslices(N, SLICE);
  localparam int             IW       = idx_width(NSL);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NSL - 1);

  if ((N % SLICE) != 0 || NSL < 1) begin : g_bad_cfg
    $error("rca_serial_nb: N must be a non-zero multiple of SLICE");
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [N-1:0]    a_q, b_q, sum_q;
  logic            carry_q, co_q, ovf_q, done_q;

  logic [N-1:0]    b_eff;
  logic            c0;
  logic            accept, last;
  logic [SLICE-1:0] sl_a, sl_b, sl_sum;
  logic            sl_co;

`ifdef SUB_EN
  // Subtraction is A + ~B + 1, so a carry out of 1 means no borrow.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_eff = bus.b;
  assign c0    = bus.cin;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sl_a = a_q[idx_q * SLICE +: SLICE];
    sl_b = b_q[idx_q * SLICE +: SLICE];
  end

  rca_slice #(.SLICE(SLICE)) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .cin (carry_q),
    .sum (sl_sum),
    .co  (sl_co)
  );

  // Upper sum slices keep the previous result until this op reaches them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= b_eff;
        carry_q <= c0;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q[idx_q * SLICE +: SLICE] <= sl_sum;
        carry_q <= sl_co;
        if (last) begin
          idx_q <= '0;
          co_q  <= sl_co;
          // The top slice is in flight, so its MSB is the result sign bit.
          ovf_q <= (a_q[N-1] == b_q[N-1]) && (sl_sum[SLICE-1] != a_q[N-1]);
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.co    = co_q;
  assign bus.ovf   = ovf_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_rca_serial_nb.sv
// Directed bench for rca_serial_nb at N=16, SLICE=4 with hand-computed results.
module tb_rca_serial_nb;
  import rca_pkg::*;

  localparam int N = 16;

  logic   clk = 1'b0;
  logic   reset;
  state_t fsm_state;
  int     n_checks = 0;
  int     n_fail   = 0;

  rca_serial_nb_if #(.N(N)) bus ();

  rca_serial_nb #(.N(N), .SLICE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic cin, input logic sub);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SUB_EN
    bus.sub   = sub;
`else
    if (sub) $display("note: subtract vector skipped without SUB_EN");
`endif
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int cnt = 0;
    while (bus.done !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, "_lat"}, cnt, exp_lat);
    check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 0);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub,
                        input logic [N-1:0] exp_sum, input logic exp_co, input logic exp_ovf);
    drive(a, b, cin, sub);
    step();
    bus.start = 1'b0;
    check({tag, "_busy"}, {31'b0, bus.busy}, 1);
    wait_done(tag, 4);
    check({tag, "_sum"}, {16'b0, bus.sum}, {16'b0, exp_sum});
    check({tag, "_co"},  {31'b0, bus.co},  {31'b0, exp_co});
    check({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, exp_ovf});
    step();
    check({tag, "_done_width"}, {31'b0, bus.done}, 0);
  endtask

  initial begin
    int done_seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SUB_EN
    bus.sub   = 1'b0;
`endif
    #12;
    check("rst_busy",  {31'b0, bus.busy}, 0);
    check("rst_done",  {31'b0, bus.done}, 0);
    check("rst_sum",   {16'b0, bus.sum},  0);
    check("rst_state", {31'b0, fsm_state}, {31'b0, IDLE});
    step();
    reset = 1'b0;
    step();

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t3", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t3b", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Start while busy must be ignored without re-sampling operands.
    drive(16'h1111, 16'h1111, 1'b0, 1'b0);
    step();
    bus.start = 1'b0;
    step();
    drive(16'hFFFF, 16'h1111, 1'b0, 1'b0);
    step();
    bus.start = 1'b0;
    check("t4_busy", {31'b0, bus.busy}, 1);
    wait_done("t4", 2);
    check("t4_sum", {16'b0, bus.sum}, 32'h2222);
    // Back-to-back start during the done cycle.
    drive(16'h000F, 16'h0001, 1'b0, 1'b0);
    step();
    bus.start = 1'b0;
    check("t4b_busy", {31'b0, bus.busy}, 1);
    check("t4b_done", {31'b0, bus.done}, 0);
    wait_done("t4b", 4);
    check("t4b_sum", {16'b0, bus.sum}, 32'h0010);
    check("t4b_co",  {31'b0, bus.co},  0);
    step();

    // Asynchronous reset mid-operation.
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
    step();
    bus.start = 1'b0;
    step();
    step();
    #1 reset = 1'b1;
    #1;
    check("t5_busy",  {31'b0, bus.busy}, 0);
    check("t5_done",  {31'b0, bus.done}, 0);
    check("t5_sum",   {16'b0, bus.sum},  0);
    check("t5_co",    {31'b0, bus.co},   0);
    check("t5_ovf",   {31'b0, bus.ovf},  0);
    check("t5_state", {31'b0, fsm_state}, {31'b0, IDLE});
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done === 1'b1) done_seen++;
    end
    check("t5_no_done", done_seen, 0);
    run_op("t5_next", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

`ifdef SUB_EN
    run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("t6b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
